// File: rtl/print_scheduler_pkg.sv
// print_sched_pkg
// Shared constants, types and helper functions for the print scheduler.
//   - radix codes for the 2-bit per-job radix field
//   - ASCII code points used by the character serializer
//   - scheduler state type
//   - ndig():     digit count for a radix and value width
//   - to_ascii(): 4-bit digit value to lowercase ASCII
package print_sched_pkg;

  localparam logic [1:0] RADIX_BIN = 2'd0;
  localparam logic [1:0] RADIX_OCT = 2'd1;
  localparam logic [1:0] RADIX_HEX = 2'd2;  // code 3 is also treated as hex

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_NL   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_NL   = 2'd2
  } sched_state_e;

  // Number of digits printed for a value of data_w bits; the top digit is
  // zero-extended when data_w is not a multiple of the digit size.
  function automatic int ndig(input logic [1:0] radix, input int data_w);
    case (radix)
      RADIX_BIN: ndig = data_w;
      RADIX_OCT: ndig = (data_w + 2) / 3;
      default:   ndig = (data_w + 3) / 4;
    endcase
  endfunction

  // Digit value 0..15 to '0'..'9' / 'a'..'f'.
  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      to_ascii = ASCII_ZERO + {4'd0, nib};
    end else begin
      to_ascii = ASCII_A_LC + {4'd0, nib} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/print_scheduler_if.sv
// print_scheduler_if
// Bundle between the message sources / character sink and the scheduler.
//   req_valid/req_ready   per-requester job handshake (ready is a one-hot grant)
//   req_data/radix/nl     job payload, requester i in slice i
//   char_valid/ready      character stream handshake towards the console
//   char_data/char_last   ASCII character and end-of-job marker
//   busy/grant_id         job in progress and its owner
// master: requesters + sink side; slave: the scheduler.
interface print_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [2*N_REQ-1:0]      req_radix;
  logic [N_REQ-1:0]        req_nl;
  logic                    char_valid;
  logic                    char_ready;
  logic [7:0]              char_data;
  logic                    char_last;
  logic                    busy;
  logic [IDW-1:0]          grant_id;

  modport master (
    output req_valid, req_data, req_radix, req_nl, char_ready,
    input  req_ready, char_valid, char_data, char_last, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_radix, req_nl, char_ready,
    output req_ready, char_valid, char_data, char_last, busy, grant_id
  );

endinterface

// File: rtl/print_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: the first set bit of req at or after ptr,
// wrapping around. Nothing is granted while en is low.
//   req  requests          ptr  search start index    en   arbitration enable
//   gnt  one-hot grant     idx  granted index         any  a grant was made
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  int             c_s;
  logic [IDW-1:0] cidx_s;
  logic           hit_s;

  // Walk the requesters starting at ptr; the first hit wins, later hits are masked by any.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    c_s    = 0;
    cidx_s = '0;
    hit_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      c_s         = (int'(ptr) + i) % N_REQ;
      cidx_s      = IDW'(c_s);
      hit_s       = en && !any && req[cidx_s];
      gnt[cidx_s] = gnt[cidx_s] | hit_s;
      idx         = hit_s ? cidx_s : idx;
      any         = any | hit_s;
    end
  end

endmodule

// File: rtl/print_scheduler.sv
// print_scheduler
// Shares one ASCII character stream among N_REQ print-job requesters.
// A job is granted in IDLE by round robin, its value is printed MSB-first as
// binary/octal/hex digits with no leading-zero suppression, optionally
// followed by a newline.
//   clk, rst  clock and synchronous active-high reset
//   bus       print_scheduler_if slave port (job handshakes, char stream,
//             busy, grant_id)
module print_scheduler
  import print_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  print_scheduler_if.slave  bus
);

  localparam int IDW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EMIT = ST_EMIT;
  localparam logic [1:0] S_NL   = ST_NL;

  logic [1:0]        state_r;
  logic [IDW-1:0]    rr_ptr_r;
  logic [IDW-1:0]    grant_id_r;
  logic [DATA_W-1:0] data_r;
  logic [1:0]        radix_r;
  logic              nl_r;
  logic [6:0]        dig_idx_r;
  logic              char_valid_r;
  logic [7:0]        char_data_r;
  logic              char_last_r;

  logic [N_REQ-1:0]  arb_gnt_s;
  logic [IDW-1:0]    arb_idx_s;
  logic              arb_any_s;
  logic              arb_en_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [1:0]        sel_radix_s;
  logic              sel_nl_s;
  logic [6:0]        first_idx_s;
  logic [7:0]        first_char_s;
  logic [6:0]        next_idx_s;
  logic [7:0]        next_char_s;

  // ASCII character of digit i (0 = least significant) of value d.
  function automatic logic [7:0] digit_char(input logic [DATA_W-1:0] d,
                                            input logic [1:0]        r,
                                            input logic [6:0]        i);
    logic [DATA_W-1:0] s;
    logic [3:0]        nib;
    case (r)
      RADIX_BIN: begin
        s   = d >> i;
        nib = {3'd0, s[0]};
      end
      RADIX_OCT: begin
        s   = d >> ({2'b00, i} * 9'd3);
        nib = {1'b0, s[2:0]};
      end
      default: begin
        s   = d >> ({2'b00, i} * 9'd4);
        nib = s[3:0];
      end
    endcase
    return to_ascii(nib);
  endfunction

  // Arbitration only happens in IDLE, so req_ready can never overlap busy.
  assign arb_en_s = (state_r == S_IDLE) && !rst;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr_r),
    .en  (arb_en_s),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .any (arb_any_s)
  );

  assign sel_data_s   = bus.req_data[int'(arb_idx_s)*DATA_W +: DATA_W];
  assign sel_radix_s  = bus.req_radix[int'(arb_idx_s)*2 +: 2];
  assign sel_nl_s     = bus.req_nl[arb_idx_s];
  assign first_idx_s  = 7'(ndig(sel_radix_s, DATA_W) - 1);
  assign first_char_s = digit_char(sel_data_s, sel_radix_s, first_idx_s);
  assign next_idx_s   = dig_idx_r - 7'd1;
  assign next_char_s  = digit_char(data_r, radix_r, next_idx_s);

  assign bus.req_ready  = arb_gnt_s;
  assign bus.char_valid = char_valid_r;
  assign bus.char_data  = char_data_r;
  assign bus.char_last  = char_last_r;
  assign bus.busy       = (state_r != S_IDLE);
  assign bus.grant_id   = grant_id_r;

  // Job FSM: grant and latch in IDLE, serialize digits in EMIT, newline in NL.
  // The character registers hold their value until the sink accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      rr_ptr_r     <= '0;
      grant_id_r   <= '0;
      data_r       <= '0;
      radix_r      <= 2'd0;
      nl_r         <= 1'b0;
      dig_idx_r    <= 7'd0;
      char_valid_r <= 1'b0;
      char_data_r  <= 8'h00;
      char_last_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (arb_any_s) begin
            state_r      <= S_EMIT;
            rr_ptr_r     <= IDW'((int'(arb_idx_s) + 1) % N_REQ);
            grant_id_r   <= arb_idx_s;
            data_r       <= sel_data_s;
            radix_r      <= sel_radix_s;
            nl_r         <= sel_nl_s;
            dig_idx_r    <= first_idx_s;
            char_valid_r <= 1'b1;
            char_data_r  <= first_char_s;
            char_last_r  <= (first_idx_s == 7'd0) && !sel_nl_s;
          end
        end
        S_EMIT: begin
          if (bus.char_ready) begin
            if (dig_idx_r == 7'd0) begin
              if (nl_r) begin
                state_r     <= S_NL;
                char_data_r <= ASCII_NL;
                char_last_r <= 1'b1;
              end else begin
                state_r      <= S_IDLE;
                char_valid_r <= 1'b0;
                char_data_r  <= 8'h00;
                char_last_r  <= 1'b0;
              end
            end else begin
              dig_idx_r   <= next_idx_s;
              char_data_r <= next_char_s;
              char_last_r <= (next_idx_s == 7'd0) && !nl_r;
            end
          end
        end
        S_NL: begin
          if (bus.char_ready) begin
            state_r      <= S_IDLE;
            char_valid_r <= 1'b0;
            char_data_r  <= 8'h00;
            char_last_r  <= 1'b0;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          char_valid_r <= 1'b0;
          char_data_r  <= 8'h00;
          char_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_print_scheduler.sv
// tb_print_scheduler
// Self-checking bench for print_scheduler (N_REQ=4, DATA_W=32). Jobs are
// queued per requester; the expected text of each granted job comes from
// $sformatf formatting of the value, and the expected grant order from a
// round-robin pointer model over the pending requests.
module tb_print_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  radix;
    bit          nl;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  print_scheduler_if #(.N_REQ(N), .DATA_W(W)) bus ();

  print_scheduler #(.N_REQ(N), .DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  job_t  jobq[N][$];
  bit    granted[N];
  byte   exp_chars[$];
  bit    exp_last[$];
  int    exp_id[$];
  int    grant_log[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    mptr     = 0;
  int    acc_cnt  = 0;
  bit    rand_rdy = 1'b0;
  bit    first_pending = 1'b0;
  bit    prev_stall = 1'b0;
  logic [9:0] stall_snap;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference text of a job.
  function automatic string fmt(job_t j);
    string s;
    case (j.radix)
      2'd0:    s = $sformatf("%032b", j.data);
      2'd1:    s = $sformatf("%011o", j.data);
      default: s = $sformatf("%08h", j.data);
    endcase
    if (j.nl) s = {s, "\n"};
    return s;
  endfunction

  task automatic push_job(int r, logic [31:0] d, logic [1:0] rad, bit nl);
    job_t j;
    j.data  = d;
    j.radix = rad;
    j.nl    = nl;
    jobq[r].push_back(j);
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (jobq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Requester and sink drivers: present the head job of each queue until it is granted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        if (jobq[i].size() > 0) jobq[i].delete(0);
        granted[i] = 1'b0;
      end
      if (jobq[i].size() > 0) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i*W +: W]   = jobq[i][0].data;
        bus.req_radix[i*2 +: 2]  = jobq[i][0].radix;
        bus.req_nl[i]            = jobq[i][0].nl;
      end else begin
        bus.req_valid[i] = 1'b0;
      end
    end
    bus.char_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor and scoreboard, sampling between active edges.
  always @(negedge clk) begin
    int g;
    int exp_g;
    string s;
    if (rst) begin
      exp_chars.delete();
      exp_last.delete();
      exp_id.delete();
      mptr          = 0;
      first_pending = 1'b0;
      prev_stall    = 1'b0;
    end else begin
      if (first_pending) begin
        check("first_char_latency", {62'd0, bus.char_valid, bus.busy}, 64'd3);
        first_pending = 1'b0;
      end
      if (prev_stall)
        check("stall_hold", {54'd0, bus.char_valid, bus.char_data, bus.char_last}, {54'd0, stall_snap});
      if (bus.req_ready != '0) begin
        g = -1;
        for (int i = N - 1; i >= 0; i--) if (bus.req_ready[i]) g = i;
        exp_g = -1;
        for (int k = N - 1; k >= 0; k--) if (bus.req_valid[(mptr + k) % N]) exp_g = (mptr + k) % N;
        check("grant_onehot", 64'($countones(bus.req_ready)), 64'd1);
        check("grant_while_busy", {63'd0, bus.busy}, 64'd0);
        check("grant_idx", 64'(g), 64'(exp_g));
        if (g >= 0 && jobq[g].size() > 0) begin
          mptr = (g + 1) % N;
          s = fmt(jobq[g][0]);
          for (int k = 0; k < s.len(); k++) begin
            exp_chars.push_back(s[k]);
            exp_last.push_back(k == s.len() - 1);
            exp_id.push_back(g);
          end
          granted[g] = 1'b1;
          grant_log.push_back(g);
          first_pending = 1'b1;
        end
      end
      if (bus.char_valid && bus.char_ready) begin
        acc_cnt++;
        if (exp_chars.size() == 0) begin
          check("extra_char", {55'd0, 1'b1, bus.char_data}, 64'd0);
        end else begin
          check("char_data", {56'd0, bus.char_data}, {56'd0, exp_chars.pop_front()});
          check("char_last", {63'd0, bus.char_last}, {63'd0, exp_last.pop_front()});
          check("grant_id", {62'd0, bus.grant_id}, 64'(exp_id.pop_front()));
        end
      end
      prev_stall = bus.char_valid && !bus.char_ready;
      stall_snap = {bus.char_valid, bus.char_data, bus.char_last};
    end
  end

  task automatic wait_done(string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((any_pending() || exp_chars.size() != 0 || bus.busy) && cyc < 20000);
    check({tag, "_timeout"}, {63'd0, cyc < 20000}, 64'd1);
  endtask

  task automatic run_one(string tag, int r, logic [31:0] d, logic [1:0] rad, bit nl, int nchars);
    int base_c;
    int base_g;
    base_c = acc_cnt;
    base_g = grant_log.size();
    push_job(r, d, rad, nl);
    wait_done(tag);
    check({tag, "_chars"}, 64'(acc_cnt - base_c), 64'(nchars));
    check({tag, "_grants"}, 64'(grant_log.size() - base_g), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_g;
    int base_c;
    int cyc;
    int exp_rr[5];
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_radix  = '0;
    bus.req_nl     = '0;
    bus.char_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready",  {60'd0, bus.req_ready}, 64'd0);
    check("rst_char_valid", {63'd0, bus.char_valid}, 64'd0);
    check("rst_char_data",  {56'd0, bus.char_data}, 64'd0);
    check("rst_char_last",  {63'd0, bus.char_last}, 64'd0);
    check("rst_busy",       {63'd0, bus.busy}, 64'd0);
    check("rst_grant_id",   {62'd0, bus.grant_id}, 64'd0);

    run_one("hex_nl",  0, 32'hDEADBEEF, 2'd2, 1'b1, 9);
    run_one("bin_5",   2, 32'h00000005, 2'd0, 1'b0, 32);
    run_one("oct_max", 3, 32'hFFFFFFFF, 2'd1, 1'b0, 11);

    // Round robin with every requester continuously valid; pointer is back at 0.
    base_g = grant_log.size();
    for (int i = 0; i < N; i++) begin
      push_job(i, 32'(i), 2'd2, 1'b1);
      push_job(i, 32'(i), 2'd2, 1'b1);
    end
    wait_done("rr");
    exp_rr = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      check("rr_order", 64'(grant_log[base_g + k]), 64'(exp_rr[k]));

    // Backpressure on the sink.
    rand_rdy = 1'b1;
    run_one("stall_hex", 0, 32'hDEADBEEF, 2'd2, 1'b1, 9);
    for (int n = 0; n < 24; n++)
      push_job($urandom_range(0, N - 1), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    wait_done("random");
    rand_rdy = 1'b0;

    // Reset in the middle of a job.
    base_c = acc_cnt;
    push_job(0, 32'hDEADBEEF, 2'd2, 1'b1);
    cyc = 0;
    while (acc_cnt < base_c + 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_rst_wait", {63'd0, cyc < 1000}, 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      jobq[i].delete();
      granted[i] = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_char_valid", {63'd0, bus.char_valid}, 64'd0);
    check("mid_rst_busy",       {63'd0, bus.busy}, 64'd0);
    check("mid_rst_char_last",  {63'd0, bus.char_last}, 64'd0);
    check("mid_rst_grant_id",   {62'd0, bus.grant_id}, 64'd0);
    run_one("after_rst", 0, 32'h12345678, 2'd2, 1'b0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/print_scheduler.md
# print_scheduler

Shares one 8-bit character output stream among N requesters that issue print jobs: $display/$write/$strobe/$monitor-style messages with binary, octal or hex radix. Round-robin grants one job at a time, serializes the latched value as ASCII digits MSB-first, and optionally appends a newline. Sits between the per-unit message sources and the console/UART transmitter.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 32, value width per job (4..64)
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- req_valid  in  N_REQ  job pending, one bit per requester
- req_ready  out  N_REQ  one-hot grant/accept strobe
- req_data  in  N_REQ*DATA_W  value, requester i at [i*DATA_W +: DATA_W]
- req_radix  in  2*N_REQ  0=bin, 1=oct, 2=hex, 3=hex
- req_nl  in  N_REQ  1 = append 0x0A (display), 0 = none (write)
- char_valid  out  1  character available
- char_ready  in  1  sink accepts character
- char_data  out  8  ASCII character
- char_last  out  1  final character of the current job
- busy  out  1  job in progress
- grant_id  out  clog2(N_REQ)  owner of the current job

## Operation
- States: IDLE, EMIT, NL.
- IDLE: if any req_valid is set, choose the first valid index at or after rr_ptr (wrapping). Assert that index's req_ready for one cycle. Latch data, radix and nl. Set grant_id. Go to EMIT with digit index = NDIG-1.
- NDIG = ceil(DATA_W/k), with k = 1/3/4 for bin/oct/hex. DATA_W=32 gives 32/11/8.
- The top digit is zero-extended when DATA_W is not a multiple of k. Example: oct, 32 bits, top digit = data[31:30].
- Digits map to '0'..'9' (0x30..0x39) and lowercase 'a'..'f' (0x61..0x66).
- No leading-zero suppression. Digit count is fixed per radix.
- EMIT: on each char_valid&&char_ready, decrement the digit index. After digit 0 is taken, go to NL if nl=1, else IDLE.
- NL: emit 0x0A. On acceptance go to IDLE.
- char_last is high with digit 0 when nl=0, and with the NL character when nl=1.
- rr_ptr updates to (granted index + 1) mod N_REQ on each grant.
- Requests not granted stay pending. Requesters must hold req_valid and payload until they see req_ready.
- req_valid dropping after grant has no effect on the running job.
- busy = (state != IDLE).

## Timing
- Reset values: req_ready=0, char_valid=0, char_data=0x00, char_last=0, busy=0, grant_id=0. Also state=IDLE, rr_ptr=0.
- rst mid-job: the job is discarded. Outputs take reset values next cycle. No partial newline is emitted.
- Grant at cycle T (req_ready high in T). char_valid rises at T+1 with the MSB digit.
- char_valid/char_data/char_last stay stable while char_ready=0. No bubbles between digits when char_ready is held high.
- Minimum job length = NDIG + nl cycles of char_valid.
- The next grant is possible in the cycle after the last character is accepted. With one requester continuously valid, there is a 1-cycle IDLE gap per job.
- A new request arriving in the same cycle as the last-character acceptance waits until IDLE arbitration.
- Arbitration is IDLE-only. req_ready is never high while busy=1.

## Structure
- Package print_sched_pkg:
  - radix codes RADIX_BIN/OCT/HEX
  - ASCII_ZERO, ASCII_A_LC, ASCII_NL
  - state enum
  - function ndig(radix, DATA_W)
  - function to_ascii(nibble)
- Sub-module rr_arbiter (N_REQ):
  - inputs: req vector, ptr, enable
  - outputs: one-hot grant, encoded index, any
  - purely combinational
  - rr_ptr register lives in print_scheduler

## Test plan
- Reset then requester 0: hex, data 0xDEADBEEF, nl=1 -> "deadbeef\n" (9 chars). char_last on 0x0A. req_ready[0] one cycle. First char one cycle after grant.
- Requester 2: bin, data 0x00000005, nl=0 -> 29 '0' then "101". 32 chars total, char_last on the last '1'.
- Oct, data 0xFFFFFFFF, nl=0 -> "37777777777" (11 chars, top digit '3').
- All 4 requesters valid continuously, each hex 0x0000000i -> grants 0,1,2,3,0 in order. grant_id matches each message.
- char_ready toggled 1/0 randomly during "deadbeef" -> output sequence identical. Data held stable while stalled. No dropped or duplicated chars.
- Assert rst for one cycle mid-job after 3 chars -> char_valid=0 next cycle. busy=0. Next job from requester 0 starts from its MSB digit.
